// File: rtl/id_ex_stage_reg_pkg.sv
// Shared core definitions for the ID/EX pipeline register: datapath widths,
// ALU opcode encoding and the control word that represents a pipeline bubble.
package id_ex_stage_reg_pkg;

    localparam int CORE_DATA_W  = 16;
    localparam int CORE_REG_AW  = 4;
    localparam int CORE_ALUOP_W = 3;
    localparam int CORE_CNT_W   = 16;

    typedef enum logic [CORE_ALUOP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } alu_op_e;

    // Control bits that must all be cleared for an instruction slot to be inert.
    typedef struct packed {
        logic valid;
        logic regWrite;
        logic memRead;
        logic memWrite;
    } ctrl_t;

    localparam ctrl_t BUBBLE_CTRL = '{valid: 1'b0, regWrite: 1'b0, memRead: 1'b0, memWrite: 1'b0};

    // Register 0 is hardwired zero, so it can never carry a real dependency.
    function automatic logic isZeroReg(input logic [CORE_REG_AW-1:0] addr);
        return (addr == {CORE_REG_AW{1'b0}});
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Load-use hazard term: the instruction in EX is a load whose destination is
// read by the instruction currently in ID. Purely combinational.
module load_use_detect
    import id_ex_stage_reg_pkg::*;
#(
    parameter int REG_AW = CORE_REG_AW
) (
    input  logic              exValid,
    input  logic              exMemRead,
    input  logic              exRegWrite,
    input  logic [REG_AW-1:0] exRd,
    input  logic              idValid,
    input  logic [REG_AW-1:0] idRs,
    input  logic [REG_AW-1:0] idRt,
    input  logic              idUsesRs,
    input  logic              idUsesRt,
    output logic              hazard
);

    logic loadInEx_s;
    logic rsMatch_s;
    logic rtMatch_s;

    // Compare the ID source operands against the destination of a load sitting in EX.
    always_comb begin
        loadInEx_s = exValid & exMemRead & exRegWrite & (exRd != {REG_AW{1'b0}});
        rsMatch_s  = idUsesRs & (idRs == exRd);
        rtMatch_s  = idUsesRt & (idRt == exRd);
        hazard     = loadInEx_s & idValid & (rsMatch_s | rtMatch_s);
    end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register. Captures decoded operands/control from ID, inserts
// a single bubble on a load-use dependency, squashes on a taken branch and
// freezes on a downstream hold. Counts inserted load-use bubbles (saturating).
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int DATA_W  = CORE_DATA_W,
    parameter int REG_AW  = CORE_REG_AW,
    parameter int ALUOP_W = CORE_ALUOP_W,
    parameter int CNT_W   = CORE_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [REG_AW-1:0]  id_rs,
    input  logic [REG_AW-1:0]  id_rt,
    input  logic [REG_AW-1:0]  id_rd,
    input  logic               id_uses_rs,
    input  logic               id_uses_rt,
    input  logic               id_reg_write,
    input  logic               id_mem_read,
    input  logic               id_mem_write,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic [DATA_W-1:0]  id_a,
    input  logic [DATA_W-1:0]  id_b,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic               flush,
    input  logic               hold,
    output logic               ex_valid,
    output logic [REG_AW-1:0]  ex_rs,
    output logic [REG_AW-1:0]  ex_rt,
    output logic [REG_AW-1:0]  ex_rd,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic [ALUOP_W-1:0] ex_alu_op,
    output logic [DATA_W-1:0]  ex_a,
    output logic [DATA_W-1:0]  ex_b,
    output logic [DATA_W-1:0]  ex_imm,
    output logic               pc_write,
    output logic               if_id_write,
    output logic [CNT_W-1:0]   stall_cnt
);

    typedef struct packed {
        ctrl_t              ctrl;
        logic [REG_AW-1:0]  rs;
        logic [REG_AW-1:0]  rt;
        logic [REG_AW-1:0]  rd;
        logic [ALUOP_W-1:0] aluOp;
        logic [DATA_W-1:0]  a;
        logic [DATA_W-1:0]  b;
        logic [DATA_W-1:0]  imm;
    } exRegs_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    exRegs_t          exRegs_r;
    exRegs_t          nextRegs_s;
    exRegs_t          bubbleRegs_s;
    logic [CNT_W-1:0] stallCnt_r;
    logic [CNT_W-1:0] nextCnt_s;
    logic             loadUseHazard_s;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) uHazard (
        .exValid    (exRegs_r.ctrl.valid),
        .exMemRead  (exRegs_r.ctrl.memRead),
        .exRegWrite (exRegs_r.ctrl.regWrite),
        .exRd       (exRegs_r.rd),
        .idValid    (id_valid),
        .idRs       (id_rs),
        .idRt       (id_rt),
        .idUsesRs   (id_uses_rs),
        .idUsesRt   (id_uses_rt),
        .hazard     (loadUseHazard_s)
    );

    // Front-end write enables: hold PC and IF/ID while a bubble is inserted or the pipe is frozen.
    always_comb begin
        pc_write    = ~(loadUseHazard_s | hold);
        if_id_write = ~(loadUseHazard_s | hold);
    end

    // Next EX contents and stall count; priority is hold > flush > hazard > load.
    always_comb begin
        bubbleRegs_s      = '0;
        bubbleRegs_s.ctrl = BUBBLE_CTRL;
        nextRegs_s        = exRegs_r;
        nextCnt_s         = stallCnt_r;
        if (hold) begin
            nextRegs_s = exRegs_r;
            nextCnt_s  = stallCnt_r;
        end else if (flush) begin
            // A squash that coincides with a hazard is not a load-use bubble.
            nextRegs_s = bubbleRegs_s;
            nextCnt_s  = stallCnt_r;
        end else if (loadUseHazard_s) begin
            nextRegs_s = bubbleRegs_s;
            if (stallCnt_r != CNT_MAX) begin
                nextCnt_s = stallCnt_r + CNT_ONE;
            end else begin
                nextCnt_s = stallCnt_r;
            end
        end else begin
            nextRegs_s.ctrl.valid    = id_valid;
            nextRegs_s.ctrl.regWrite = id_reg_write & id_valid;
            nextRegs_s.ctrl.memRead  = id_mem_read & id_valid;
            nextRegs_s.ctrl.memWrite = id_mem_write & id_valid;
            nextRegs_s.rs            = id_rs;
            nextRegs_s.rt            = id_rt;
            nextRegs_s.rd            = id_rd;
            nextRegs_s.aluOp         = id_alu_op;
            nextRegs_s.a             = id_a;
            nextRegs_s.b             = id_b;
            nextRegs_s.imm           = id_imm;
            nextCnt_s                = stallCnt_r;
        end
    end

    // Pipeline register and stall counter; reset leaves a bubble in EX.
    always_ff @(posedge clk) begin
        if (rst) begin
            exRegs_r   <= '0;
            stallCnt_r <= {CNT_W{1'b0}};
        end else begin
            exRegs_r   <= nextRegs_s;
            stallCnt_r <= nextCnt_s;
        end
    end

    assign ex_valid     = exRegs_r.ctrl.valid;
    assign ex_reg_write = exRegs_r.ctrl.regWrite;
    assign ex_mem_read  = exRegs_r.ctrl.memRead;
    assign ex_mem_write = exRegs_r.ctrl.memWrite;
    assign ex_rs        = exRegs_r.rs;
    assign ex_rt        = exRegs_r.rt;
    assign ex_rd        = exRegs_r.rd;
    assign ex_alu_op    = exRegs_r.aluOp;
    assign ex_a         = exRegs_r.a;
    assign ex_b         = exRegs_r.b;
    assign ex_imm       = exRegs_r.imm;
    assign stall_cnt    = stallCnt_r;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg (built with a 4-bit stall counter so
// saturation is reachable quickly). The driver pushes hand-computed expected
// EX contents and expected pc_write per cycle; two monitors pop and compare.
module tb_id_ex_stage_reg;
    import id_ex_stage_reg_pkg::*;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int OW = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          id_valid = 1'b0;
    logic [AW-1:0] id_rs = 4'd0, id_rt = 4'd0, id_rd = 4'd0;
    logic          id_uses_rs = 1'b0, id_uses_rt = 1'b0;
    logic          id_reg_write = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
    logic [OW-1:0] id_alu_op = 3'd0;
    logic [DW-1:0] id_a = 16'h0, id_b = 16'h0, id_imm = 16'h0;
    logic          flush = 1'b0, hold = 1'b0;
    logic          ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [AW-1:0] ex_rs, ex_rt, ex_rd;
    logic [OW-1:0] ex_alu_op;
    logic [DW-1:0] ex_a, ex_b, ex_imm;
    logic          pc_write, if_id_write;
    logic [CW-1:0] stall_cnt;

    id_ex_stage_reg #(.DATA_W(DW), .REG_AW(AW), .ALUOP_W(OW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_alu_op(id_alu_op),
        .id_a(id_a), .id_b(id_b), .id_imm(id_imm), .flush(flush), .hold(hold),
        .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_alu_op(ex_alu_op), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .pc_write(pc_write), .if_id_write(if_id_write), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic valid; logic [AW-1:0] rs, rt, rd;
        logic usesRs, usesRt, rw, mr, mw;
        logic [OW-1:0] alu; logic [DW-1:0] a, b, imm;
    } inst_t;

    typedef struct packed {
        logic valid; logic [AW-1:0] rs, rt, rd;
        logic rw, mr, mw;
        logic [OW-1:0] alu; logic [DW-1:0] a, b, imm;
        logic [CW-1:0] cnt;
    } exp_t;

    typedef struct { int tag; exp_t e; } exItem_t;
    typedef struct { int tag; logic chk; logic pcw; } pcItem_t;

    exItem_t exQ[$];
    pcItem_t pcQ[$];
    int tests = 0;
    int fails = 0;
    int tagN  = 0;

    function automatic inst_t mk(input logic v, input logic [AW-1:0] rs, rt, rd,
                                 input logic urs, urt, rw, mr, mw,
                                 input logic [OW-1:0] alu, input logic [DW-1:0] a, b, imm);
        inst_t i;
        i.valid = v; i.rs = rs; i.rt = rt; i.rd = rd;
        i.usesRs = urs; i.usesRt = urt; i.rw = rw; i.mr = mr; i.mw = mw;
        i.alu = alu; i.a = a; i.b = b; i.imm = imm;
        return i;
    endfunction

    function automatic inst_t lw(input logic [AW-1:0] rd, rs, input logic [DW-1:0] a, imm);
        return mk(1'b1, rs, rd, rd, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, ALU_ADD, a, 16'h0000, imm);
    endfunction

    function automatic inst_t add(input logic [AW-1:0] rd, rs, rt, input logic [DW-1:0] a, b);
        return mk(1'b1, rs, rt, rd, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, ALU_ADD, a, b, 16'h0000);
    endfunction

    // Expected EX contents when ID is captured: fields copied, control gated by valid.
    function automatic exp_t loadExp(input inst_t i, input logic [CW-1:0] c);
        exp_t e;
        e.valid = i.valid; e.rs = i.rs; e.rt = i.rt; e.rd = i.rd;
        e.rw = i.rw & i.valid; e.mr = i.mr & i.valid; e.mw = i.mw & i.valid;
        e.alu = i.alu; e.a = i.a; e.b = i.b; e.imm = i.imm; e.cnt = c;
        return e;
    endfunction

    function automatic exp_t bubbleExp(input logic [CW-1:0] c);
        exp_t e;
        e = '0;
        e.cnt = c;
        return e;
    endfunction

    task automatic step(input logic r, input inst_t i, input logic fl, input logic hd,
                        input exp_t e, input logic chk, input logic pcw);
        exItem_t xi;
        pcItem_t pi;
        @(negedge clk);
        rst = r; id_valid = i.valid; id_rs = i.rs; id_rt = i.rt; id_rd = i.rd;
        id_uses_rs = i.usesRs; id_uses_rt = i.usesRt; id_reg_write = i.rw;
        id_mem_read = i.mr; id_mem_write = i.mw; id_alu_op = i.alu;
        id_a = i.a; id_b = i.b; id_imm = i.imm; flush = fl; hold = hd;
        xi.tag = tagN; xi.e = e;
        pi.tag = tagN; pi.chk = chk; pi.pcw = pcw;
        exQ.push_back(xi);
        pcQ.push_back(pi);
        tagN++;
    endtask

    // EX-side monitor: registered outputs after each active edge.
    initial begin
        forever begin
            exItem_t it;
            exp_t    act;
            @(posedge clk);
            #1;
            if (exQ.size() > 0) begin
                it  = exQ.pop_front();
                act = {ex_valid, ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read, ex_mem_write,
                       ex_alu_op, ex_a, ex_b, ex_imm, stall_cnt};
                tests++;
                if (act !== it.e) begin
                    fails++;
                    $display("FAIL ex_regs step %0d act=%h exp=%h", it.tag, act, it.e);
                end
            end
        end
    end

    // Front-end enable monitor: combinational outputs mid-cycle, after inputs settle.
    initial begin
        forever begin
            pcItem_t pt;
            @(negedge clk);
            #2;
            if (pcQ.size() > 0) begin
                pt = pcQ.pop_front();
                if (pt.chk) begin
                    tests++;
                    if (pc_write !== pt.pcw || if_id_write !== pt.pcw) begin
                        fails++;
                        $display("FAIL pc_write step %0d act=%b/%b exp=%b", pt.tag, pc_write, if_id_write, pt.pcw);
                    end
                end
            end
        end
    end

    initial begin
        logic [95:0]   r96;
        inst_t         rnd, lw3, add435, nopI, lw0, add405, lw6, add716, addi, sw, lw7, add871;
        exp_t          held;
        logic [CW-1:0] c;

        lw3    = lw(4'd3, 4'd1, 16'h0100, 16'h0010);
        add435 = add(4'd4, 4'd3, 4'd5, 16'h1111, 16'h2222);
        nopI   = mk(1'b0, 4'd1, 4'd2, 4'd9, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, ALU_SUB, 16'hAAAA, 16'h5555, 16'h0F0F);
        lw0    = lw(4'd0, 4'd1, 16'h0200, 16'h0004);
        add405 = add(4'd4, 4'd0, 4'd5, 16'h0000, 16'h3333);
        lw6    = lw(4'd6, 4'd2, 16'h0300, 16'h0008);
        add716 = add(4'd7, 4'd1, 4'd6, 16'h0101, 16'h0606);
        addi   = mk(1'b1, 4'd2, 4'd6, 4'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, ALU_OR, 16'h0300, 16'h0000, 16'h00FF);
        sw     = mk(1'b1, 4'd2, 4'd6, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, ALU_ADD, 16'h0300, 16'h0606, 16'h000C);
        lw7    = lw(4'd7, 4'd2, 16'h1234, 16'h0002);
        add871 = add(4'd8, 4'd7, 4'd1, 16'h1234, 16'h0101);

        // Reset with random ID contents and a flush: EX must come out as a bubble.
        r96 = {$urandom, $urandom, $urandom}; rnd = r96[$bits(inst_t)-1:0];
        step(1'b1, rnd, 1'b1, 1'b0, bubbleExp(4'd0), 1'b1, 1'b1);
        r96 = {$urandom, $urandom, $urandom}; rnd = r96[$bits(inst_t)-1:0];
        step(1'b1, rnd, 1'b0, 1'b0, bubbleExp(4'd0), 1'b1, 1'b1);

        // Load-use on rs: one bubble, then the dependent ADD enters EX.
        step(1'b0, lw3,    1'b0, 1'b0, loadExp(lw3, 4'd0),    1'b1, 1'b1);
        step(1'b0, add435, 1'b0, 1'b0, bubbleExp(4'd1),       1'b1, 1'b0);
        step(1'b0, add435, 1'b0, 1'b0, loadExp(add435, 4'd1), 1'b1, 1'b1);
        step(1'b0, nopI,   1'b0, 1'b0, loadExp(nopI, 4'd1),   1'b1, 1'b1);

        // Load into r0 never stalls.
        step(1'b0, lw0,    1'b0, 1'b0, loadExp(lw0, 4'd1),    1'b1, 1'b1);
        step(1'b0, add405, 1'b0, 1'b0, loadExp(add405, 4'd1), 1'b1, 1'b1);

        // Flush coinciding with hazard: bubble, not counted, PC still held.
        step(1'b0, lw3,    1'b0, 1'b0, loadExp(lw3, 4'd1),    1'b1, 1'b1);
        step(1'b0, add435, 1'b1, 1'b0, bubbleExp(4'd1),       1'b1, 1'b0);
        step(1'b0, add435, 1'b0, 1'b0, loadExp(add435, 4'd1), 1'b1, 1'b1);

        // Dependency through rt.
        step(1'b0, lw6,    1'b0, 1'b0, loadExp(lw6, 4'd1),    1'b1, 1'b1);
        step(1'b0, add716, 1'b0, 1'b0, bubbleExp(4'd2),       1'b1, 1'b0);
        step(1'b0, add716, 1'b0, 1'b0, loadExp(add716, 4'd2), 1'b1, 1'b1);

        // Immediate form whose rt field matches but is not read: no stall.
        step(1'b0, lw6,    1'b0, 1'b0, loadExp(lw6, 4'd2),    1'b1, 1'b1);
        step(1'b0, addi,   1'b0, 1'b0, loadExp(addi, 4'd2),   1'b1, 1'b1);

        // Store data depending on the preceding load still stalls.
        step(1'b0, lw6,    1'b0, 1'b0, loadExp(lw6, 4'd2),    1'b1, 1'b1);
        step(1'b0, sw,     1'b0, 1'b0, bubbleExp(4'd3),       1'b1, 1'b0);
        step(1'b0, sw,     1'b0, 1'b0, loadExp(sw, 4'd3),     1'b1, 1'b1);

        // Hold with a pending hazard: frozen 3 cycles, counted once after release.
        held = loadExp(lw7, 4'd3);
        step(1'b0, lw7,    1'b0, 1'b0, held, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, add871, 1'b0, 1'b1, held, 1'b1, 1'b0);
        end
        step(1'b0, add871, 1'b0, 1'b0, bubbleExp(4'd4),       1'b1, 1'b0);
        step(1'b0, add871, 1'b0, 1'b0, loadExp(add871, 4'd4), 1'b1, 1'b1);

        // Plain hold of an ALU instruction, flush ignored while frozen, then normal load.
        held = loadExp(add871, 4'd4);
        step(1'b0, nopI,   1'b0, 1'b1, held, 1'b1, 1'b0);
        step(1'b0, lw3,    1'b1, 1'b1, held, 1'b1, 1'b0);
        step(1'b0, add435, 1'b0, 1'b0, loadExp(add435, 4'd4), 1'b1, 1'b1);

        // Repeated load-use pairs drive the counter into saturation.
        c = 4'd4;
        for (int k = 0; k < 14; k++) begin
            step(1'b0, lw3, 1'b0, 1'b0, loadExp(lw3, c), 1'b1, 1'b1);
            c = (c == 4'hF) ? c : c + 4'd1;
            step(1'b0, add435, 1'b0, 1'b0, bubbleExp(c), 1'b1, 1'b0);
        end
        step(1'b0, lw3,    1'b0, 1'b0, loadExp(lw3, 4'hF),    1'b1, 1'b1);
        step(1'b0, add435, 1'b1, 1'b0, bubbleExp(4'hF),       1'b1, 1'b0);

        // Give the monitors a bounded window to drain the scoreboard.
        repeat (3) @(negedge clk);
        tests++;
        if (exQ.size() != 0 || pcQ.size() != 0) begin
            fails++;
            $display("FAIL drain act=%0d/%0d pending exp=0", exQ.size(), pcQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
